// File: rtl/wb_ext_arbiter_pkg.sv
// Shared types for the external Wishbone arbiter.
package wb_ext_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_ABORT
    } arb_state_e;

endpackage

// File: rtl/wb_ext_arbiter_arb_rr.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module arb_rr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Shares one external Wishbone slave among tile masters: round-robin, grant held
// for the whole bus cycle, per-transfer timeout answered with ERR.
module wb_ext_arbiter
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_w,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]      m_cyc,
    input  logic [NUM_MASTERS-1:0]      m_stb,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS-1:0]      m_cab,
    input  logic [NUM_MASTERS*3-1:0]    m_cti,
    input  logic [NUM_MASTERS*2-1:0]    m_bte,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [NUM_MASTERS-1:0]      m_err,
    output logic [NUM_MASTERS-1:0]      m_rty,
    output logic [DW-1:0]               m_dat_r,
    output logic [AW-1:0]               s_adr,
    output logic [DW-1:0]               s_dat_w,
    output logic [DW/8-1:0]             s_sel,
    output logic                        s_cyc,
    output logic                        s_stb,
    output logic                        s_we,
    output logic                        s_cab,
    output logic [2:0]                  s_cti,
    output logic [1:0]                  s_bte,
    input  logic                        s_ack,
    input  logic                        s_err,
    input  logic                        s_rty,
    input  logic [DW-1:0]               s_dat_r,
    output logic [NUM_MASTERS-1:0]      grant,
    output logic                        timeout_evt
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = DW / 8;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, pick_gnt;
    logic [IW-1:0]          idx_q, idx_d, ptr_q, ptr_d, pick_idx, idx_next;
    logic [TW-1:0]          cnt_q;
    logic                   own, abort, resp, hit;

    arb_rr #(.N(NUM_MASTERS), .IW(IW)) u_arb_rr (
        .req     (m_cyc),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign own      = (state_q == ST_OWN);
    assign abort    = (state_q == ST_ABORT);
    assign resp     = s_ack | s_err | s_rty;
    assign idx_next = (idx_q == IW'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;
    assign hit      = own && s_stb && !resp && (cnt_q == TW'(TIMEOUT - 1));

    assign s_cyc   = own & m_cyc[idx_q];
    assign s_stb   = own & m_stb[idx_q];
    assign s_we    = own & m_we[idx_q];
    assign s_cab   = own & m_cab[idx_q];
    assign s_adr   = own ? m_adr[idx_q*AW +: AW]   : '0;
    assign s_dat_w = own ? m_dat_w[idx_q*DW +: DW] : '0;
    assign s_sel   = own ? m_sel[idx_q*SW +: SW]   : '0;
    assign s_cti   = own ? m_cti[idx_q*3 +: 3]     : '0;
    assign s_bte   = own ? m_bte[idx_q*2 +: 2]     : '0;

    // Responses outside OWN are dropped, so a late slave answer never leaks.
    assign m_ack       = grant_q & {NUM_MASTERS{own & s_ack}};
    assign m_err       = grant_q & {NUM_MASTERS{(own & s_err) | abort}};
    assign m_rty       = grant_q & {NUM_MASTERS{own & s_rty}};
    assign m_dat_r     = s_dat_r;
    assign grant       = grant_q;
    assign timeout_evt = abort;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d = ST_OWN;
                    grant_d = pick_gnt;
                    idx_d   = pick_idx;
                end
            end
            ST_OWN: begin
                // Timeout takes precedence over the owner releasing the bus.
                if (hit) begin
                    state_d = ST_ABORT;
                end else if (!m_cyc[idx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = idx_next;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = idx_next;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            if (!own || !s_stb || resp) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Scoreboard bench for wb_ext_arbiter: randomized master rounds, a behavioural
// slave, and a round-robin owner model kept at transaction level.
module tb_wb_ext_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    typedef struct {
        int          idx;
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_cyc, m_stb, m_we, m_cab;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [N-1:0]    m_ack, m_err, m_rty;
    logic [DW-1:0]   m_dat_r;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [SW-1:0]   s_sel;
    logic            s_cyc, s_stb, s_we, s_cab;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic            s_ack, s_err, s_rty;
    logic [DW-1:0]   s_dat_r;
    logic [N-1:0]    grant;
    logic            timeout_evt;

    exp_t        sb[$];
    exp_t        mon_e;
    int          exp_order[$];
    int          checks = 0;
    int          errors = 0;
    int          mdl_ptr = 0;
    int          nb[N];
    int          beat[N];
    logic [31:0] base[N];
    logic        wr[N];
    bit          active[N];
    bit          again[N];
    bit          raise_next[N];
    logic [N-1:0] preset = '0;
    int          slv_wait = 0;
    int          slv_lat = 0;
    int          lat_mode = -1;

    always #5 clk = ~clk;

    wb_ext_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_cab(m_cab),
        .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_r(m_dat_r),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cab(s_cab),
        .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_r(s_dat_r),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    function automatic logic [31:0] rdData(input logic [31:0] a);
        return a ^ 32'h5EAD_BEFF;
    endfunction

    function automatic logic [31:0] wrData(input logic [31:0] a);
        return ~a;
    endfunction

    // The slave never answers anything mapped into this region.
    function automatic bit isDead(input logic [31:0] a);
        return a[31:16] == 16'hDEAD;
    endfunction

    function automatic int ohIdx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveMaster(input int i, input bit on);
        logic [31:0] a;
        logic [2:0]  cti;
        a   = base[i] + 32'(4 * beat[i]);
        cti = (nb[i] == 1) ? 3'b000 : (beat[i] == nb[i] - 1) ? 3'b111 : 3'b010;
        m_cyc[i] = on;
        m_stb[i] = on;
        m_we[i]  = wr[i];
        m_cab[i] = on && (nb[i] > 1);
        m_adr[i*AW +: AW]   = a;
        m_dat_w[i*DW +: DW] = wrData(a);
        m_sel[i*SW +: SW]   = '1;
        m_cti[i*3 +: 3]     = cti;
        m_bte[i*2 +: 2]     = 2'b00;
    endtask

    task automatic slaveStep();
        if (s_cyc && s_stb && !isDead(s_adr)) begin
            if (slv_wait >= slv_lat) begin
                s_ack   = 1'b1;
                s_dat_r = s_we ? 32'h0 : rdData(s_adr);
                if (s_we) checkOutput("s_dat_w", s_dat_w, wrData(s_adr));
                slv_wait = 0;
                slv_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                s_ack = 1'b0;
                slv_wait++;
            end
        end else begin
            s_ack    = 1'b0;
            slv_wait = 0;
        end
    endtask

    // Transaction-level model: serve pending masters in rotating order from the
    // pointer; a master that re-requests joins the back of the rotation.
    task automatic modelRound(input logic [N-1:0] mask, input logic [N-1:0] rer);
        bit pend[N];
        bit rr[N];
        int k;
        logic [31:0] a;
        exp_order.delete();
        for (int i = 0; i < N; i++) begin
            pend[i] = mask[i];
            rr[i]   = rer[i];
        end
        for (int n = 0; n < 2 * N; n++) begin
            k = -1;
            for (int j = 0; j < N; j++)
                if (k < 0 && pend[(mdl_ptr + j) % N]) k = (mdl_ptr + j) % N;
            if (k < 0) break;
            exp_order.push_back(k);
            if (isDead(base[k])) begin
                sb.push_back('{k, 1'b1, 1'b0, 32'h0});
            end else begin
                for (int b = 0; b < nb[k]; b++) begin
                    a = base[k] + 32'(4 * b);
                    sb.push_back('{k, 1'b0, !wr[k], rdData(a)});
                end
            end
            pend[k] = 0;
            mdl_ptr = (k + 1) % N;
            if (rr[k]) begin
                rr[k]   = 0;
                pend[k] = 1;
            end
        end
    endtask

    // One round: masters in mask request together; rer masters re-request once.
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] rer, input int lat);
        logic [N-1:0] g, prev_g, ack_v, err_v;
        int  own_start, n_act;
        int  obs[$];
        bit  done_all;
        lat_mode  = lat;
        slv_lat   = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        slv_wait  = 0;
        done_all  = 0;
        own_start = 0;
        prev_g    = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !preset[i]) begin
                nb[i]   = int'($urandom_range(1, 4));
                base[i] = $urandom & 32'h7FFF_FFF0;
                wr[i]   = 1'($urandom_range(0, 1));
            end
        end
        modelRound(mask, rer);
        for (int i = 0; i < N; i++) begin
            again[i]      = rer[i];
            raise_next[i] = 0;
            beat[i]       = 0;
            active[i]     = mask[i];
            if (mask[i]) driveMaster(i, 1'b1);
        end
        #1 slaveStep();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g     = grant;
            ack_v = m_ack;
            err_v = m_err;
            if (c == 0) checkOutput("grant_before_arb", 32'(g), 32'h0);
            if (c == 1) checkOutput("grant_latency", 32'(g), 32'(1 << exp_order[0]));
            if (g != '0 && g != prev_g) begin
                checkOutput("idle_gap", 32'(prev_g), 32'h0);
                obs.push_back(ohIdx(g));
                own_start = c;
            end
            if (err_v != '0) begin
                checkOutput("timeout_latency", 32'(c - own_start), 32'(TO));
                checkOutput("s_cyc_in_abort", 32'(s_cyc), 32'h0);
            end
            prev_g = g;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (raise_next[i]) begin
                    raise_next[i] = 0;
                    beat[i]       = 0;
                    active[i]     = 1;
                    driveMaster(i, 1'b1);
                end else if (active[i] && (ack_v[i] || err_v[i])) begin
                    beat[i]++;
                    if (err_v[i] || beat[i] == nb[i]) begin
                        active[i] = 0;
                        m_cyc[i]  = 1'b0;
                        m_stb[i]  = 1'b0;
                        if (again[i]) begin
                            again[i]      = 0;
                            raise_next[i] = 1;
                        end
                    end else begin
                        driveMaster(i, 1'b1);
                    end
                end
            end
            #1 slaveStep();
            n_act = 0;
            for (int i = 0; i < N; i++) if (active[i] || raise_next[i]) n_act++;
            if (n_act == 0) begin
                done_all = 1;
                break;
            end
        end
        if (!done_all) begin
            checks++;
            errors++;
            $display("[TB] FAIL round_budget: round mask %b still busy after 3000 cycles", mask);
            m_cyc = '0;
            m_stb = '0;
        end
        checkOutput("owner_count", 32'(obs.size()), 32'(exp_order.size()));
        for (int j = 0; j < obs.size() && j < exp_order.size(); j++)
            checkOutput("owner_order", 32'(obs[j]), 32'(exp_order[j]));
        preset = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && ((m_ack | m_err | m_rty) != '0)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: ack=%b err=%b rty=%b, expected none", m_ack, m_err, m_rty);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("resp_ack", 32'(m_ack), mon_e.is_err ? 32'h0 : 32'(1 << mon_e.idx));
                checkOutput("resp_err", 32'(m_err), mon_e.is_err ? 32'(1 << mon_e.idx) : 32'h0);
                checkOutput("resp_rty", 32'(m_rty), 32'h0);
                checkOutput("timeout_evt", 32'(timeout_evt), 32'(mon_e.is_err));
                if (!mon_e.is_err && mon_e.is_read)
                    checkOutput("m_dat_r", m_dat_r, mon_e.data);
            end
        end else if (rst_n) begin
            checkOutput("timeout_evt_quiet", 32'(timeout_evt), 32'h0);
        end
    end

    initial begin
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cyc = '0; m_stb = '0;
        m_we = '0; m_cab = '0; m_cti = '0; m_bte = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_r = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("rst_s_stb", 32'(s_stb), 32'h0);
        checkOutput("rst_m_resp", 32'(m_ack | m_err | m_rty), 32'h0);
        checkOutput("rst_timeout_evt", 32'(timeout_evt), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single classic read by master 2.
        preset = 4'b0100; nb[2] = 1; base[2] = 32'h8000_0010; wr[2] = 1'b0;
        applyStimulus(4'b0100, 4'b0000, 3);

        // Master 3 hits a dead slave region and is aborted; master 0 follows.
        preset = 4'b1000; nb[3] = 1; base[3] = 32'hDEAD_0000; wr[3] = 1'b0;
        applyStimulus(4'b1001, 4'b0000, -1);

        // Master 1 4-beat incrementing burst while master 3 waits.
        preset = 4'b0010; nb[1] = 4; base[1] = $urandom & 32'h7FFF_FFF0; wr[1] = 1'b0;
        applyStimulus(4'b1010, 4'b0000, 0);

        // Ack arrives in the very cycle the timeout would fire.
        applyStimulus(4'b0001, 4'b0000, TO - 1);

        // Asynchronous reset during the second beat of a master 0 burst.
        nb[0] = 4; base[0] = $urandom & 32'h7FFF_FFF0; wr[0] = 1'b0; beat[0] = 0;
        sb.push_back('{0, 1'b0, 1'b1, rdData(base[0])});
        lat_mode = 0; slv_lat = 0; slv_wait = 0;
        driveMaster(0, 1'b1);
        #1 slaveStep();
        @(posedge clk);
        #1;
        #1 slaveStep();
        @(posedge clk);
        #1;
        beat[0] = 1;
        driveMaster(0, 1'b1);
        #1 slaveStep();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("async_rst_grant", 32'(grant), 32'h0);
        checkOutput("async_rst_m_ack", 32'(m_ack), 32'h0);
        checkOutput("async_rst_sb_drained", 32'(sb.size()), 32'h0);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_ptr = 0;
        @(posedge clk);
        #1;

        // All four from reset; master 0 re-requests straight after its turn.
        applyStimulus(4'b1111, 4'b0001, -1);

        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] mask, rer;
            mask = 4'($urandom_range(1, 15));
            rer  = 4'($urandom_range(0, 15)) & mask;
            applyStimulus(mask, rer, -1);
        end

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ext_arbiter.md
Name: wb_ext_arbiter

Overview:
- Shares one external Wishbone slave (e.g. a board DRAM controller) between the per-tile wb_ext master buses of a compute-tile system.
- Arbitration is round-robin and holds a grant for the whole bus cycle, including CTI bursts.
- A per-transfer timeout returns ERR to the owning tile, so a dead slave cannot hang the system.
- Sits at system top level, between the flattened tile wb_ext_* vectors and the single board-level slave port.

Parameters:
- NUM_MASTERS, 4, number of tile masters (>=2).
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 1024, cycles STB may wait for ACK/ERR/RTY before the arbiter aborts (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_adr  in  NUM_MASTERS*AW  per-master address; master i in slice [(i+1)*AW-1:i*AW]. All m_* vectors slice the same way.
- m_dat_w  in  NUM_MASTERS*DW  write data.
- m_sel  in  NUM_MASTERS*DW/8  byte selects.
- m_cyc, m_stb, m_we, m_cab  in  NUM_MASTERS each  control.
- m_cti  in  NUM_MASTERS*3  cycle type.
- m_bte  in  NUM_MASTERS*2  burst type.
- m_ack, m_err, m_rty  out  NUM_MASTERS each  responses.
- m_dat_r  out  DW  read data, broadcast to all masters.
- s_adr  out  AW  slave address.
- s_dat_w  out  DW  slave write data.
- s_sel  out  DW/8  slave byte selects.
- s_cyc, s_stb, s_we, s_cab  out  1 each  slave control.
- s_cti  out  3  slave cycle type.
- s_bte  out  2  slave burst type.
- s_ack, s_err, s_rty  in  1 each  slave responses.
- s_dat_r  in  DW  slave read data.
- grant  out  NUM_MASTERS  one-hot current owner (status/debug).
- timeout_evt  out  1  one-cycle pulse on each abort.

Behaviour:
- Reset (rst_n=0, async): state IDLE; grant=0; prio pointer=0; timeout counter=0. All s_cyc/s_stb/m_ack/m_err/m_rty/timeout_evt = 0. Reset mid-cycle aborts the transfer silently.
- FSM IDLE -> OWN -> (ABORT) -> IDLE.
- IDLE:
  - Scan m_cyc starting at prio pointer, wrapping modulo NUM_MASTERS.
  - On the first set bit, register grant and go to OWN. Grant is visible one cycle after the request (1-cycle arbitration latency).
  - No request: stay IDLE.
- OWN:
  - s_adr, s_dat_w, s_sel, s_we, s_cab, s_cti, s_bte, s_cyc and s_stb are combinational muxes of the granted master.
  - s_ack/s_err/s_rty route combinationally to the granted master only; all other m_ack/m_err/m_rty stay 0.
  - Grant holds while granted m_cyc=1, across any number of ACKs (classic, incrementing and end-of-burst CTI all identical).
  - Granted m_cyc=0: go to IDLE in the same edge; prio pointer := granted index+1 mod NUM_MASTERS. Earliest re-grant is 1 cycle later (1 idle bus cycle between owners).
  - Timeout counter:
    - clears on any s_ack/s_err/s_rty, and whenever s_stb=0;
    - increments while s_stb=1 with no response.
    - On reaching TIMEOUT-1 with no response: go to ABORT.
- ABORT (one cycle):
  - s_cyc=s_stb=0.
  - Granted m_err=1 for exactly this cycle; timeout_evt=1.
  - Then IDLE; prio pointer advances as above.
  - A late slave response in ABORT or IDLE is dropped.
- Simultaneous events:
  - s_ack in the same cycle the counter hits TIMEOUT-1: the ack wins, no abort.
  - Granted master drops m_cyc in the same cycle as ABORT entry: the abort still happens.
- When not in OWN, s_* outputs are driven to 0; m_dat_r = s_dat_r always.
- Starvation bound: a requester waits at most NUM_MASTERS-1 complete foreign cycles.

Decomposition:
- No shared-package content required.
- Timeout width is $clog2(TIMEOUT), computed locally.
- One natural sub-module: arb_rr (NUM_MASTERS-wide round-robin priority picker: req, prio pointer in, one-hot grant out). Reusable elsewhere in the codebase's NoC/debug arbiters.

Test Plan:
- Single request: m_cyc[2]=1, classic read at 0x8000_0010, slave acks after 3 cycles with 0xDEAD_BEEF. Required: grant=4'b0100 one cycle after request; m_ack[2] pulses once; m_dat_r=0xDEAD_BEEF; other m_ack=0.
- All four request from reset: order granted 0,1,2,3. Re-raising master 0 immediately after its cycle is served only after master 3.
- Burst: master 1 issues a 4-beat incrementing burst (cti 010,010,010,111). Required: grant stays 4'b0010 across all 4 acks with no idle gap; master 3 requesting concurrently is granted only after m_cyc[1] falls.
- Timeout: TIMEOUT=16, slave never responds to master 3. Required: m_err[3]=1 and timeout_evt=1 exactly 16 cycles after s_stb rose; s_cyc=0 that cycle; next requester granted afterwards.
- Ack/timeout race: s_ack asserted exactly in the cycle the counter reaches TIMEOUT-1. Required: m_ack=1, m_err=0, no timeout_evt.
- Async reset mid-burst: rst_n low during beat 2 of master 0's burst. Required: s_cyc, grant and m_ack go to 0 without waiting for clk; after release, arbitration restarts at master 0.
